// File: rtl/player_cmd_issuer_if.sv
// rtl/player_cmd_issuer_if.sv - event, movement and instruction signals of the player command issuer
interface player_cmd_issuer_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    move_req;
  logic          is_dead;

  logic          sethp_valid;
  logic [7:0]    sethp_value;
  logic          sethp_ready;

  logic          dmg_valid;
  logic [7:0]    dmg_amount;
  logic          dmg_ready;

  logic          heal_valid;
  logic [7:0]    heal_amount;
  logic          heal_ready;

  logic          atk_valid;
  logic [7:0]    atk_amount;
  logic          atk_ready;

  logic [15:0]   instruction;
  logic [CW-1:0] fifo_count;

  // game-logic / input layer side
  modport master (
    output move_req, is_dead,
    output sethp_valid, sethp_value, dmg_valid, dmg_amount,
    output heal_valid, heal_amount, atk_valid, atk_amount,
    input  sethp_ready, dmg_ready, heal_ready, atk_ready,
    input  instruction, fifo_count
  );

  // issuer side
  modport slave (
    input  move_req, is_dead,
    input  sethp_valid, sethp_value, dmg_valid, dmg_amount,
    input  heal_valid, heal_amount, atk_valid, atk_amount,
    output sethp_ready, dmg_ready, heal_ready, atk_ready,
    output instruction, fifo_count
  );
endinterface

// File: rtl/player_cmd_issuer.sv
// rtl/player_cmd_issuer.sv - serialises game events and movement ticks into player instruction words
module player_cmd_issuer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int MOVE_PERIOD = 833333
) (
  input logic               clk,
  input logic               reset,
  player_cmd_issuer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(MOVE_PERIOD);

  // source index 0..3 is also the grant priority: sethp, dmg, heal, atk
  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic [TW-1:0] tick_cnt;
  logic          move_pending;
  logic [1:0]    rr_ptr;
  logic [15:0]   instr_q;

  logic [3:0]    src_valid, src_ready, push;
  logic [11:0]   src_word [4];
  logic [2:0]    slot_off [4];
  logic [2:0]    push_cnt;
  logic [2:0]    higher;
  logic          pop;
  logic          wrap;
  logic          dir_found;
  logic [1:0]    dir_sel;
  logic [1:0]    cand;

  assign src_valid   = {bus.atk_valid, bus.heal_valid, bus.dmg_valid, bus.sethp_valid};
  assign src_word[0] = {4'b0110, bus.sethp_value};
  assign src_word[1] = {4'b0010, bus.dmg_amount};
  assign src_word[2] = {4'b0001, bus.heal_amount};
  assign src_word[3] = {4'b0011, bus.atk_amount};

  assign free = CW'(FIFO_DEPTH) - count;
  assign pop  = (count != '0);
  assign wrap = (tick_cnt == TW'(MOVE_PERIOD - 1));

  assign bus.sethp_ready = src_ready[0];
  assign bus.dmg_ready   = src_ready[1];
  assign bus.heal_ready  = src_ready[2];
  assign bus.atk_ready   = src_ready[3];
  assign bus.instruction = instr_q;
  assign bus.fifo_count  = count;

  // a source is ready only if a slot remains after every higher-priority valid takes one
  always_comb begin
    higher = '0;
    for (int i = 0; i < 4; i++) begin
      src_ready[i] = (free > CW'(higher));
      higher       = higher + 3'(src_valid[i]);
    end
  end

  // accepted sources fill consecutive slots in priority order
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      push[i]     = src_valid[i] & src_ready[i];
      slot_off[i] = push_cnt;
      push_cnt    = push_cnt + 3'(push[i]);
    end
  end

  // round-robin pick of the first held direction at or after rr_ptr
  always_comb begin
    dir_found = 1'b0;
    dir_sel   = rr_ptr;
    cand      = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (bus.move_req[cand]) begin
        dir_found = 1'b1;
        dir_sel   = cand;
      end
    end
  end

  // event storage, written without reset since occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[wr_ptr + AW'(slot_off[i])] <= src_word[i];
    end
  end

  // queue pointers, output word selection and movement tick bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      instr_q      <= 16'h0000;
      tick_cnt     <= '0;
      move_pending <= 1'b0;
      rr_ptr       <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_cnt);
      count  <= count + CW'(push_cnt) - CW'(pop);

      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        instr_q <= {mem[rd_ptr], 4'h0};
      end else if (move_pending && dir_found && !bus.is_dead) begin
        instr_q <= {4'b0101, 6'b0, dir_sel, 4'h0};
        rr_ptr  <= dir_sel + 2'd1;
      end else begin
        instr_q <= 16'h0000;
      end

      // a pending move is consumed (emitted or dropped) whenever the queue is empty;
      // a fresh tick on that same edge re-arms it
      if (wrap) begin
        tick_cnt     <= '0;
        move_pending <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
        if (!pop) move_pending <= 1'b0;
      end
    end
  end
endmodule
